// File: rtl/btn_loader.sv
// btn_loader: input stage for top_alu. Synchronises and debounces the three load buttons and
// the switch bank, then turns each accepted press into a one-cycle load pulse.
//
// Ports:
//   clk       system clock
//   rst       asynchronous, active-low reset
//   btn_a     raw push-button, load operand A
//   btn_b     raw push-button, load operand B
//   btn_op    raw push-button, load opcode
//   sw_in     raw switch bank
//   en_a      one-cycle load pulse, operand A
//   en_b      one-cycle load pulse, operand B
//   en_op     one-cycle load pulse, opcode
//   sw_out    switch value captured on the edge that raised the current/last en_*
//   last_sel  last issued load: 00 none, 01 A, 10 B, 11 OP
module btn_loader #(
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned SW_W      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_a,
    input  logic            btn_b,
    input  logic            btn_op,
    input  logic [SW_W-1:0] sw_in,
    output logic            en_a,
    output logic            en_b,
    output logic            en_op,
    output logic [SW_W-1:0] sw_out,
    output logic [1:0]      last_sel
);

    localparam int unsigned CntW = $clog2(DB_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {StLow, StRise, StHigh, StFall} db_state_e;

    // Index 0 = A, 1 = B, 2 = OP; lower index wins arbitration.
    logic [2:0]      btn_s1_q, btn_s2_q;
    logic [SW_W-1:0] sw_s1_q, sw_s2_q;

    db_state_e       state_q [3];
    db_state_e       state_d [3];
    logic [CntW-1:0] cnt_q   [3];
    logic [CntW-1:0] cnt_d   [3];
    logic [2:0]      req;

    logic [2:0]      pend_q, pend_d;
    logic [2:0]      pend_eff;
    logic [2:0]      grant;
    logic [2:0]      en_q, en_d;
    logic [SW_W-1:0] sw_out_q, sw_out_d;
    logic [1:0]      last_sel_q, last_sel_d;

    // Debounce FSMs: a level change is accepted only after DB_CYCLES further stable samples.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            req[i]     = 1'b0;
            case (state_q[i])
                StLow: begin
                    if (btn_s2_q[i]) begin
                        state_d[i] = StRise;
                        cnt_d[i]   = '0;
                    end
                end
                StRise: begin
                    if (!btn_s2_q[i]) begin
                        state_d[i] = StLow;
                    end else if (cnt_q[i] == CntMax) begin
                        state_d[i] = StHigh;
                        req[i]     = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntW'(1);
                    end
                end
                StHigh: begin
                    if (!btn_s2_q[i]) begin
                        state_d[i] = StFall;
                        cnt_d[i]   = '0;
                    end
                end
                StFall: begin
                    if (btn_s2_q[i]) begin
                        state_d[i] = StHigh;
                    end else if (cnt_q[i] == CntMax) begin
                        state_d[i] = StLow;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntW'(1);
                    end
                end
                default: state_d[i] = StLow;
            endcase
        end
    end

    // Arbiter: a fresh request can be issued on the same edge it is raised, so an
    // uncontested press costs only one cycle here.
    always_comb begin
        pend_eff   = pend_q | req;
        grant      = 3'b000;
        if (pend_eff[0]) begin
            grant = 3'b001;
        end else if (pend_eff[1]) begin
            grant = 3'b010;
        end else if (pend_eff[2]) begin
            grant = 3'b100;
        end
        pend_d     = pend_eff & ~grant;
        en_d       = grant;
        sw_out_d   = sw_out_q;
        last_sel_d = last_sel_q;
        if (grant != 3'b000) begin
            sw_out_d = sw_s2_q;
        end
        unique case (grant)
            3'b001:  last_sel_d = 2'b01;
            3'b010:  last_sel_d = 2'b10;
            3'b100:  last_sel_d = 2'b11;
            default: last_sel_d = last_sel_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= StLow;
                cnt_q[i]   <= '0;
            end
            pend_q     <= '0;
            en_q       <= '0;
            sw_out_q   <= '0;
            last_sel_q <= 2'b00;
        end else begin
            btn_s1_q   <= {btn_op, btn_b, btn_a};
            btn_s2_q   <= btn_s1_q;
            sw_s1_q    <= sw_in;
            sw_s2_q    <= sw_s1_q;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pend_q     <= pend_d;
            en_q       <= en_d;
            sw_out_q   <= sw_out_d;
            last_sel_q <= last_sel_d;
        end
    end

    assign en_a     = en_q[0];
    assign en_b     = en_q[1];
    assign en_op    = en_q[2];
    assign sw_out   = sw_out_q;
    assign last_sel = last_sel_q;

endmodule

// File: tb/tb_btn_loader.sv
// Bench for btn_loader with DB_CYCLES=4: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a behavioural model.
module tb_btn_loader;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_a = 1'b0, btn_b = 1'b0, btn_op = 1'b0;
    logic [7:0] sw_in = 8'h00;
    logic       en_a, en_b, en_op;
    logic [7:0] sw_out;
    logic [1:0] last_sel;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit cmp_on = 1'b0;

    btn_loader #(.DB_CYCLES(DB), .SW_W(8)) dut (
        .clk(clk), .rst(rst), .btn_a(btn_a), .btn_b(btn_b), .btn_op(btn_op), .sw_in(sw_in),
        .en_a(en_a), .en_b(en_b), .en_op(en_op), .sw_out(sw_out), .last_sel(last_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: each input is seen two edges late; a button's accepted level flips
    // after DB+1 consecutive samples disagreeing with it, and a 0->1 flip is a request.
    bit         m_s1 [3], m_s2 [3], m_acc [3], m_pend [3];
    int         m_run [3];
    logic [7:0] m_sw1, m_sw2;
    logic [2:0] exp_en;
    logic [7:0] exp_sw;
    logic [1:0] exp_sel;

    initial begin : model
        bit raw [3];
        int g;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                for (int i = 0; i < 3; i++) begin
                    m_s1[i] = 0; m_s2[i] = 0; m_acc[i] = 0; m_pend[i] = 0; m_run[i] = 0;
                end
                m_sw1 = 0; m_sw2 = 0; exp_en = 0; exp_sw = 0; exp_sel = 0;
            end else begin
                raw[0] = btn_a; raw[1] = btn_b; raw[2] = btn_op;
                for (int i = 0; i < 3; i++) begin
                    if (m_s2[i] == m_acc[i]) begin
                        m_run[i] = 0;
                    end else begin
                        m_run[i]++;
                        if (m_run[i] == DB + 1) begin
                            m_acc[i] = m_s2[i];
                            m_run[i] = 0;
                            if (m_s2[i]) m_pend[i] = 1;
                        end
                    end
                end
                g = -1;
                for (int i = 0; i < 3; i++) if (m_pend[i] && g < 0) g = i;
                exp_en = 3'b000;
                if (g >= 0) begin
                    exp_en[g] = 1'b1;
                    m_pend[g] = 0;
                    exp_sw    = m_sw2;
                    exp_sel   = 2'(g + 1);
                end
                for (int i = 0; i < 3; i++) begin
                    m_s2[i] = m_s1[i];
                    m_s1[i] = raw[i];
                end
                m_sw2 = m_sw1;
                m_sw1 = sw_in;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                check("en", {29'd0, en_op, en_b, en_a}, {29'd0, exp_en});
                check("sw_out", {24'd0, sw_out}, {24'd0, exp_sw});
                check("last_sel", {30'd0, last_sel}, {30'd0, exp_sel});
            end
        end
    end

    // Pulse monitor: counts, cycle of last pulse, and the outputs seen with it.
    int         pc [3];
    int         plast [3];
    logic [7:0] psw [3];
    logic [1:0] psel [3];

    initial begin : monitor
        logic [2:0] e;
        for (int i = 0; i < 3; i++) pc[i] = 0;
        forever begin
            @(negedge clk);
            e = {en_op, en_b, en_a};
            for (int i = 0; i < 3; i++) begin
                if (e[i]) begin
                    pc[i]++;
                    plast[i] = cyc;
                    psw[i]   = sw_out;
                    psel[i]  = last_sel;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : timeout
        #2_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin : stim
        int k, c0, c2;
        tick(3);
        #1;
        check("reset_en", {29'd0, en_op, en_b, en_a}, 32'd0);
        check("reset_sw", {24'd0, sw_out}, 32'd0);
        check("reset_sel", {30'd0, last_sel}, 32'd0);
        cmp_on = 1'b1;
        @(negedge clk); #2 rst = 1'b1;
        tick(5);

        // Clean press
        sw_in = 8'h05; btn_a = 1'b1; k = cyc; c0 = pc[0];
        tick(12);
        check("clean_count", 32'(pc[0] - c0), 32'd1);
        check("clean_latency", 32'(plast[0] - k), 32'd7);
        check("clean_sw", {24'd0, psw[0]}, 32'h05);
        check("clean_sel", {30'd0, psel[0]}, 32'd1);
        btn_a = 1'b0;
        tick(12);

        // Bounce on B
        sw_in = 8'h03; c0 = pc[1];
        for (int j = 0; j < 10; j++) begin
            btn_b = (j % 2 == 0);
            tick(2);
        end
        check("bounce_quiet", 32'(pc[1] - c0), 32'd0);
        btn_b = 1'b1; k = cyc;
        tick(12);
        check("bounce_count", 32'(pc[1] - c0), 32'd1);
        check("bounce_latency", 32'(plast[1] - k), 32'd7);
        btn_b = 1'b0;
        tick(12);

        // Simultaneous A and OP
        c0 = pc[0]; c2 = pc[2];
        btn_a = 1'b1; btn_op = 1'b1; k = cyc;
        tick(12);
        check("simul_a_lat", 32'(plast[0] - k), 32'd7);
        check("simul_op_lat", 32'(plast[2] - k), 32'd8);
        check("simul_a_sel", {30'd0, psel[0]}, 32'd1);
        check("simul_op_sel", {30'd0, psel[2]}, 32'd3);
        check("simul_counts", 32'((pc[0] - c0) + (pc[2] - c2)), 32'd2);
        btn_a = 1'b0; btn_op = 1'b0;
        tick(12);

        // Long hold on OP with a short glitch, then a real re-press
        sw_in = 8'h20; c2 = pc[2];
        btn_op = 1'b1; tick(100);
        btn_op = 1'b0; tick(2);
        btn_op = 1'b1; tick(20);
        check("long_short_release", 32'(pc[2] - c2), 32'd1);
        btn_op = 1'b0; tick(20);
        btn_op = 1'b1; tick(20);
        check("long_total", 32'(pc[2] - c2), 32'd2);
        check("long_sw", {24'd0, psw[2]}, 32'h20);
        btn_op = 1'b0;
        tick(12);

        // Reset two cycles into RISE with the button held
        btn_b = 1'b1; c0 = pc[1];
        tick(4);
        #2 rst = 1'b0;
        #1;
        check("midrst_en", {29'd0, en_op, en_b, en_a}, 32'd0);
        check("midrst_sw", {24'd0, sw_out}, 32'd0);
        check("midrst_sel", {30'd0, last_sel}, 32'd0);
        tick(2);
        #2 rst = 1'b1; k = cyc;
        tick(12);
        check("midrst_count", 32'(pc[1] - c0), 32'd1);
        check("midrst_latency", 32'(plast[1] - k), 32'd7);
        btn_b = 1'b0;
        tick(12);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) btn_a = ~btn_a;
            if ($urandom_range(0, 7) == 0) btn_b = ~btn_b;
            if ($urandom_range(0, 7) == 0) btn_op = ~btn_op;
            if ($urandom_range(0, 3) == 0) sw_in = 8'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
            end
        end
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
